formula_simplifier: RTL
=======================

Name: formula_simplifier

Overview:
- Downstream of the unit-clause finder in the DPLL datapath: takes the current formula and one assigned literal (normally lit_found), and produces the reduced formula.
- Reduction rules: every clause containing the literal is deleted; every occurrence of its complement is removed from the remaining clauses.
- Processes one clause per clock and compacts surviving clauses to the front of the output array.
- Reports an empty-clause conflict or an empty (satisfied) formula to the controlling FSM.

Parameters:
- NUMBER_CLAUSES, 16, clause slots in a formula (same value as the common package constant).
- NUMBER_LITERALS, 4, literal slots per clause.
- VAR_BITS, 6, variable-index width; a lit is {neg (1 bit, MSB), var (VAR_BITS)}.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- simplify  input  1  start request; sampled only in IDLE.
- in_formula  input  formula  formula to reduce (clauses[], per-clause len, formula len).
- in_lit  input  lit  literal made true.
- ended  output  1  one-cycle pulse when the operation finishes.
- busy  output  1  high while in SCAN.
- conflict  output  1  an empty clause was produced.
- empty  output  1  no clauses remain (formula satisfied).
- out_formula  output  formula  reduced formula.

Behaviour:
- States are IDLE and SCAN. Registers:
  - s_in_formula and s_lit (input captures)
  - read index i and write index w (clog2(NUMBER_CLAUSES)+1 bits)
  - output regs
- Reset (asynchronous, any state, including mid-SCAN):
  - state is IDLE, i and w are 0.
  - ended, busy, conflict and empty are 0.
  - out_formula is all-zero with len 0.
- IDLE with simplify=1 at an edge:
  - Capture in_formula and in_lit.
  - i<=0, w<=0, conflict<=0, empty<=0, out_formula<=zero.
  - Go to SCAN.
- simplify while busy, or in the capture cycle, is ignored. No queuing.
- SCAN, per edge, with i < min(s_in_formula.len, NUMBER_CLAUSES): examine clause i, lits 0..len-1 only.
  - Any lit equal to s_lit: clause dropped; w unchanged.
  - Otherwise: remove all lits equal to the complement (neg flipped, same var), keeping order. Write the result to out_formula.clauses[w], zero-fill slots ≥ new len, then w<=w+1.
  - A clause with both s_lit and its complement counts as satisfied and is dropped.
  - New clause len 0: conflict<=1, ended<=1, go to IDLE at this same edge. Later clauses are not examined, and out_formula content is don't-care.
  - i<=i+1.
- SCAN, edge with i >= min(s_in_formula.len, NUMBER_CLAUSES):
  - out_formula.len<=w, empty<=(w==0), ended<=1, go to IDLE.
- Latency, capture edge = edge 0:
  - No conflict: ended is high after edge L+1, where L = min(len, NUMBER_CLAUSES).
  - len=0 input: ended after edge 1 with empty=1.
  - Conflict at clause k: ended after edge k+1.
- ended is high for exactly one cycle.
- conflict, empty and out_formula hold until the next accepted simplify or reset.
- busy = (state==SCAN).
- Input clause len 0 is treated as an existing conflict: it is flagged at its index.
- Input len > NUMBER_CLAUSES is clamped to NUMBER_CLAUSES.
- Clause len > NUMBER_LITERALS is clamped to NUMBER_LITERALS.
- Per-clause literal removal is combinational within the cycle (prefix-count compaction over NUMBER_LITERALS slots).

Test Plan:
- Satisfied removal: clauses {(+1,+2),(-3),(+1)}, lit +1, simplify pulse.
  - ended after edge 4; out len 1 = {(-3)}; conflict=0; empty=0.
- Complement removal and compaction: clauses {(-2,+4,-2),(+5)}, lit +2.
  - out {(+4),(+5)}, clause 0 len 1 with slots 1..3 zero; ended after edge 3.
- Conflict: clauses {(+7),(-6),(+8)}, lit +6.
  - conflict=1 and ended after edge 2; busy low next cycle; clause 2 never examined.
- Empty result and len=0 input:
  - {(+3,-4),(+3)} with lit +3 gives empty=1, out len 0, ended after edge 3.
  - len=0 input gives empty=1 with ended after edge 1.
- Handshake robustness:
  - Holding simplify high through SCAN starts no second operation.
  - Asserting simplify in the cycle after ended starts a new run with the new inputs.
- Asynchronous reset mid-SCAN (after edge 2 of a 10-clause run): outputs zero immediately, without waiting for a clock edge. A following simplify runs correctly from clause 0.

Source files
------------

// File: rtl/formula_simplifier_if.sv
// Handshake and formula buses between the DPLL controller and the formula simplifier.
// A formula is carried as clause literals, per-clause lengths and the clause count.
interface formula_simplifier_if #(
  parameter int NUMBER_CLAUSES  = 16,
  parameter int NUMBER_LITERALS = 4,
  parameter int VAR_BITS        = 6
);
  localparam int FL_W = $clog2(NUMBER_CLAUSES) + 1;
  localparam int CL_W = $clog2(NUMBER_LITERALS) + 1;

  logic                                                simplify;
  logic [NUMBER_CLAUSES-1:0][NUMBER_LITERALS-1:0][VAR_BITS:0] in_clauses;
  logic [NUMBER_CLAUSES-1:0][CL_W-1:0]                 in_clause_len;
  logic [FL_W-1:0]                                     in_len;
  logic [VAR_BITS:0]                                   in_lit;
  logic                                                ended;
  logic                                                busy;
  logic                                                conflict;
  logic                                                empty;
  logic [NUMBER_CLAUSES-1:0][NUMBER_LITERALS-1:0][VAR_BITS:0] out_clauses;
  logic [NUMBER_CLAUSES-1:0][CL_W-1:0]                 out_clause_len;
  logic [FL_W-1:0]                                     out_len;

  modport master (
    output simplify, in_clauses, in_clause_len, in_len, in_lit,
    input  ended, busy, conflict, empty, out_clauses, out_clause_len, out_len
  );

  modport slave (
    input  simplify, in_clauses, in_clause_len, in_len, in_lit,
    output ended, busy, conflict, empty, out_clauses, out_clause_len, out_len
  );
endinterface

// File: rtl/formula_simplifier.sv
// Applies one assigned literal to a formula, one clause per clock: drops satisfied
// clauses, strips the complement literal, compacts survivors and flags conflict/empty.
module formula_simplifier #(
  parameter int NUMBER_CLAUSES  = 16,
  parameter int NUMBER_LITERALS = 4,
  parameter int VAR_BITS        = 6
) (
  input logic                clock,
  input logic                reset,
  formula_simplifier_if.slave bus
);
  localparam int CI_W  = $clog2(NUMBER_CLAUSES);
  localparam int FL_W  = CI_W + 1;
  localparam int CL_W  = $clog2(NUMBER_LITERALS) + 1;
  localparam int LIT_W = VAR_BITS + 1;

  typedef logic [LIT_W-1:0] lit_t;
  typedef lit_t [NUMBER_LITERALS-1:0] clause_t;
  typedef enum logic {IDLE, SCAN} state_t;

  state_t                              state_reg, state_next;
  clause_t [NUMBER_CLAUSES-1:0]        s_clauses_reg, s_clauses_next;
  logic [NUMBER_CLAUSES-1:0][CL_W-1:0] s_clause_len_reg, s_clause_len_next;
  logic [FL_W-1:0]                     s_len_reg, s_len_next;
  lit_t                                s_lit_reg, s_lit_next;
  logic [FL_W-1:0]                     i_reg, i_next, w_reg, w_next;
  logic                                ended_reg, ended_next;
  logic                                conflict_reg, conflict_next;
  logic                                empty_reg, empty_next;
  clause_t [NUMBER_CLAUSES-1:0]        out_clauses_reg, out_clauses_next;
  logic [NUMBER_CLAUSES-1:0][CL_W-1:0] out_clause_len_reg, out_clause_len_next;
  logic [FL_W-1:0]                     out_len_reg, out_len_next;

  logic [FL_W-1:0]            limit;
  clause_t                    cur_lits;
  logic [CL_W-1:0]            cur_len_raw, cur_len;
  lit_t                       comp_lit;
  logic [NUMBER_LITERALS-1:0] valid, match, keep;
  logic [CL_W-1:0]            pos [NUMBER_LITERALS+1];
  clause_t                    new_clause;
  logic [CL_W-1:0]            new_len;
  logic                       has_lit;

  assign limit       = (s_len_reg > FL_W'(NUMBER_CLAUSES)) ? FL_W'(NUMBER_CLAUSES) : s_len_reg;
  assign cur_lits    = s_clauses_reg[i_reg[CI_W-1:0]];
  assign cur_len_raw = s_clause_len_reg[i_reg[CI_W-1:0]];
  assign cur_len     = (cur_len_raw > CL_W'(NUMBER_LITERALS)) ? CL_W'(NUMBER_LITERALS) : cur_len_raw;
  assign comp_lit    = {~s_lit_reg[VAR_BITS], s_lit_reg[VAR_BITS-1:0]};

  // pos[k] is the output slot of literal k: number of kept literals before it
  assign pos[0] = '0;
  for (genvar gi = 0; gi < NUMBER_LITERALS; gi++) begin : g_slot
    assign valid[gi]  = CL_W'(gi) < cur_len;
    assign match[gi]  = valid[gi] && (cur_lits[gi] == s_lit_reg);
    assign keep[gi]   = valid[gi] && (cur_lits[gi] != comp_lit);
    assign pos[gi+1]  = pos[gi] + CL_W'(keep[gi]);
  end

  assign has_lit = |match;
  assign new_len = pos[NUMBER_LITERALS];

  always_comb begin
    new_clause = '0;
    for (int j = 0; j < NUMBER_LITERALS; j++)
      for (int k = 0; k < NUMBER_LITERALS; k++)
        if (keep[k] && pos[k] == CL_W'(j))
          new_clause[j] = cur_lits[k];
  end

  always_comb begin
    state_next          = state_reg;
    s_clauses_next      = s_clauses_reg;
    s_clause_len_next   = s_clause_len_reg;
    s_len_next          = s_len_reg;
    s_lit_next          = s_lit_reg;
    i_next              = i_reg;
    w_next              = w_reg;
    ended_next          = 1'b0;
    conflict_next       = conflict_reg;
    empty_next          = empty_reg;
    out_clauses_next    = out_clauses_reg;
    out_clause_len_next = out_clause_len_reg;
    out_len_next        = out_len_reg;
    case (state_reg)
      IDLE: begin
        if (bus.simplify) begin
          s_clauses_next      = bus.in_clauses;
          s_clause_len_next   = bus.in_clause_len;
          s_len_next          = bus.in_len;
          s_lit_next          = bus.in_lit;
          i_next              = '0;
          w_next              = '0;
          conflict_next       = 1'b0;
          empty_next          = 1'b0;
          out_clauses_next    = '0;
          out_clause_len_next = '0;
          out_len_next        = '0;
          state_next          = SCAN;
        end
      end
      SCAN: begin
        if (i_reg < limit) begin
          if (!has_lit) begin
            if (new_len == '0) begin
              conflict_next = 1'b1;
              ended_next    = 1'b1;
              state_next    = IDLE;
            end else begin
              out_clauses_next[w_reg[CI_W-1:0]]    = new_clause;
              out_clause_len_next[w_reg[CI_W-1:0]] = new_len;
              w_next = w_reg + FL_W'(1);
            end
          end
          i_next = i_reg + FL_W'(1);
        end else begin
          out_len_next = w_reg;
          empty_next   = (w_reg == '0);
          ended_next   = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg          <= IDLE;
      s_clauses_reg      <= '0;
      s_clause_len_reg   <= '0;
      s_len_reg          <= '0;
      s_lit_reg          <= '0;
      i_reg              <= '0;
      w_reg              <= '0;
      ended_reg          <= 1'b0;
      conflict_reg       <= 1'b0;
      empty_reg          <= 1'b0;
      out_clauses_reg    <= '0;
      out_clause_len_reg <= '0;
      out_len_reg        <= '0;
    end else begin
      state_reg          <= state_next;
      s_clauses_reg      <= s_clauses_next;
      s_clause_len_reg   <= s_clause_len_next;
      s_len_reg          <= s_len_next;
      s_lit_reg          <= s_lit_next;
      i_reg              <= i_next;
      w_reg              <= w_next;
      ended_reg          <= ended_next;
      conflict_reg       <= conflict_next;
      empty_reg          <= empty_next;
      out_clauses_reg    <= out_clauses_next;
      out_clause_len_reg <= out_clause_len_next;
      out_len_reg        <= out_len_next;
    end
  end

  assign bus.ended          = ended_reg;
  assign bus.busy           = (state_reg == SCAN);
  assign bus.conflict       = conflict_reg;
  assign bus.empty          = empty_reg;
  assign bus.out_clauses    = out_clauses_reg;
  assign bus.out_clause_len = out_clause_len_reg;
  assign bus.out_len        = out_len_reg;
endmodule
